// File: rtl/serial_link_pkg.sv
// Shared types, defaults and helpers for the serial link master.
package serial_link_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // $clog2 that never returns 0, so single-entry indices still get one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_link_master_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter
    import serial_link_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IW    = clog2_min1(N_REQ)
) (
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt_c,
    output logic [IW-1:0]    idx_c
);

    logic          found;
    logic [IW-1:0] cand;
    int            sum;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = '0;
        sum   = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            sum  = int'(ptr) + k;
            cand = (sum >= int'(N_REQ)) ? IW'(sum - int'(N_REQ)) : IW'(sum);
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                gnt_c[cand]  = 1'b1;
                idx_c        = cand;
            end
        end
    end

endmodule

// File: rtl/serial_link_master.sv
// Round-robin shared master for WIDTH-bit full-duplex frames to select-addressed slaves.
module serial_link_master
    import serial_link_pkg::*;
#(
    parameter  int unsigned N_REQ   = 2,
    parameter  int unsigned N_SLV   = 4,
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    parameter  int unsigned CLK_DIV = DEF_CLK_DIV,
    localparam int unsigned SW      = clog2_min1(N_SLV)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ*SW-1:0]    req_slave,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [N_SLV-1:0]       sel_n
);

    localparam int unsigned IW = clog2_min1(N_REQ);
    localparam int unsigned DW = clog2_min1(CLK_DIV);
    localparam int unsigned BW = clog2_min1(WIDTH);

    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_SETUP = 3'(SETUP);
    localparam logic [2:0] ST_SHIFT = 3'(SHIFT);
    localparam logic [2:0] ST_HOLD  = 3'(HOLD);
    localparam logic [2:0] ST_DONE  = 3'(DONE);

    logic [2:0]       state, state_d;
    logic [DW-1:0]    div_cnt, div_d;
    logic [BW-1:0]    bit_cnt, bit_d;
    logic [WIDTH-1:0] tx, tx_d, rx, rx_d, rsp_data_d, tx_sh;
    logic [SW-1:0]    slv, slv_d;
    logic [IW-1:0]    gidx, gidx_d, ptr, ptr_d, ptr_nxt;
    logic             sclk_d, mosi_d, busy_d, div_last, slv_ok;
    logic [N_SLV-1:0] sel_n_d;
    logic [N_REQ-1:0] req_ready_d, rsp_valid_d, gnt_c;
    logic [IW-1:0]    idx_c;

    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [SW-1:0]    slv_arr  [N_REQ];
    logic [SW-1:0]    pick_slv;

    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        assign slv_arr[gi]  = req_slave[gi*SW +: SW];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .en    (state == ST_IDLE),
        .req   (req_valid),
        .ptr   (ptr),
        .gnt_c (gnt_c),
        .idx_c (idx_c)
    );

    assign pick_slv = slv_arr[idx_c];
    assign ptr_nxt  = (int'(idx_c) + 1 >= int'(N_REQ)) ? '0 : idx_c + IW'(1);
    assign div_last = (div_cnt == DW'(CLK_DIV - 1));
    assign slv_ok   = (32'(slv) < N_SLV);
    assign tx_sh    = tx << 1;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        div_d       = div_cnt;
        bit_d       = bit_cnt;
        tx_d        = tx;
        rx_d        = rx;
        slv_d       = slv;
        gidx_d      = gidx;
        ptr_d       = ptr;
        sclk_d      = sclk;
        mosi_d      = mosi;
        sel_n_d     = sel_n;
        busy_d      = busy;
        rsp_data_d  = rsp_data;
        req_ready_d = '0;
        rsp_valid_d = '0;

        case (state)
            ST_IDLE: begin
                if (|gnt_c) begin
                    req_ready_d = gnt_c;
                    gidx_d      = idx_c;
                    ptr_d       = ptr_nxt;
                    tx_d        = data_arr[idx_c];
                    slv_d       = pick_slv;
                    mosi_d      = data_arr[idx_c][WIDTH-1];
                    for (int i = 0; i < int'(N_SLV); i++) begin
                        sel_n_d[i] = (pick_slv != SW'(i));
                    end
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    rx_d    = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_cnt + DW'(1);
                end
            end
            ST_SHIFT: begin
                if (!div_last) begin
                    div_d = div_cnt + DW'(1);
                end else begin
                    div_d = '0;
                    if (sclk) begin
                        // Capture at end of high phase, then launch next bit on the falling edge
                        rx_d   = (rx << 1) | WIDTH'(miso);
                        sclk_d = 1'b0;
                        if (bit_cnt != BW'(WIDTH - 1)) begin
                            tx_d   = tx_sh;
                            mosi_d = tx_sh[WIDTH-1];
                        end
                    end else if (bit_cnt == BW'(WIDTH - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d  = bit_cnt + BW'(1);
                        sclk_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    sel_n_d = '1;
                    state_d = ST_DONE;
                end else begin
                    div_d = div_cnt + DW'(1);
                end
            end
            ST_DONE: begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    rsp_valid_d[i] = (gidx == IW'(i));
                end
                rsp_data_d = slv_ok ? rx : '0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_n_d = '1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            slv       <= '0;
            gidx      <= '0;
            ptr       <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            sel_n     <= '1;
            busy      <= 1'b0;
            rsp_data  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_d;
            bit_cnt   <= bit_d;
            tx        <= tx_d;
            rx        <= rx_d;
            slv       <= slv_d;
            gidx      <= gidx_d;
            ptr       <= ptr_d;
            sclk      <= sclk_d;
            mosi      <= mosi_d;
            sel_n     <= sel_n_d;
            busy      <= busy_d;
            rsp_data  <= rsp_data_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_link_master.sv
// Bench for serial_link_master: default instance (A) and an 8-bit/div-1/3-slave instance (B).
module tb_serial_link_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  req_valid_a, req_ready_a, rsp_valid_a;
    logic [7:0]  req_data_a;
    logic [3:0]  req_slave_a, rsp_data_a, sel_n_a;
    logic        busy_a, sclk_a, mosi_a, miso_a;

    logic [1:0]  req_valid_b, req_ready_b, rsp_valid_b;
    logic [15:0] req_data_b;
    logic [3:0]  req_slave_b;
    logic [7:0]  rsp_data_b;
    logic [2:0]  sel_n_b;
    logic        busy_b, sclk_b, mosi_b, miso_b;

    serial_link_master u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_slave(req_slave_a), .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .busy(busy_a), .sclk(sclk_a), .mosi(mosi_a),
        .miso(miso_a), .sel_n(sel_n_a)
    );

    serial_link_master #(.N_REQ(2), .N_SLV(3), .WIDTH(8), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_slave(req_slave_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(miso_b), .sel_n(sel_n_b)
    );

    // Slave side: 0 loopback, 1 tied low, 2 tied high, 3 shift-register slave (sreg MSB)
    logic       dsel;
    int         mode;
    logic [7:0] sreg;
    assign miso_a = (mode == 0) ? mosi_a : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : sreg[7];
    assign miso_b = (mode == 0) ? mosi_b : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : sreg[7];

    logic [1:0] o_ready, o_rsp_valid;
    logic [7:0] o_rsp_data;
    logic [3:0] o_sel_n;
    logic       o_sclk, o_mosi, o_busy;
    assign o_ready     = dsel ? req_ready_b : req_ready_a;
    assign o_rsp_valid = dsel ? rsp_valid_b : rsp_valid_a;
    assign o_rsp_data  = dsel ? rsp_data_b : {4'b0, rsp_data_a};
    assign o_sel_n     = dsel ? {1'b1, sel_n_b} : sel_n_a;
    assign o_sclk      = dsel ? sclk_b : sclk_a;
    assign o_mosi      = dsel ? mosi_b : mosi_a;
    assign o_busy      = dsel ? busy_b : busy_a;

    int checks = 0;
    int errors = 0;
    int rr_ptr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [7:0] data, input logic [1:0] slv, input logic v);
        if (dsel) begin
            if (r == 0) begin req_valid_b[0] = v; req_data_b[7:0]  = data; req_slave_b[1:0] = slv; end
            else        begin req_valid_b[1] = v; req_data_b[15:8] = data; req_slave_b[3:2] = slv; end
        end else begin
            if (r == 0) begin req_valid_a[0] = v; req_data_a[3:0] = data[3:0]; req_slave_a[1:0] = slv; end
            else        begin req_valid_a[1] = v; req_data_a[7:4] = data[3:0]; req_slave_a[3:2] = slv; end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sel_n_a", 32'(sel_n_a), 32'hF);
        check_eq("rst_sel_n_b", 32'(sel_n_b), 32'h7);
        check_eq("rst_sclk", 32'({sclk_a, sclk_b}), 32'h0);
        check_eq("rst_mosi", 32'({mosi_a, mosi_b}), 32'h0);
        check_eq("rst_busy", 32'({busy_a, busy_b}), 32'h0);
        check_eq("rst_ready", 32'({req_ready_a, req_ready_b}), 32'h0);
        check_eq("rst_rsp_valid", 32'({rsp_valid_a, rsp_valid_b}), 32'h0);
        check_eq("rst_rsp_data", 32'({rsp_data_a, rsp_data_b}), 32'h0);
        rst_n  = 1'b1;
        rr_ptr = 0;
    endtask

    // One complete transaction from a single requester on the selected DUT
    task automatic frame(input int r, input logic [7:0] data, input logic [1:0] slv,
                         input int md, input logic [7:0] sword);
        int w, d, nslv, cyc, pulses, highs, early;
        logic [7:0] mask, exp_rsp, cap;
        logic [3:0] exp_sel;
        logic got, done, prev;
        w    = dsel ? 8 : 4;
        d    = dsel ? 1 : 4;
        nslv = dsel ? 3 : 4;
        mask = dsel ? 8'hFF : 8'h0F;
        mode = md;
        sreg = dsel ? sword : {sword[3:0], 4'b0};
        exp_sel = 4'hF;
        if (int'(slv) < nslv) exp_sel[slv] = 1'b0;
        if (int'(slv) >= nslv) exp_rsp = 8'h0;
        else case (md)
            0:       exp_rsp = data & mask;
            1:       exp_rsp = 8'h0;
            2:       exp_rsp = mask;
            default: exp_rsp = sword & mask;
        endcase

        set_req(r, data, slv, 1'b1);
        got = 1'b0;
        early = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (o_rsp_valid != 2'b0) early++;
            got = (o_ready != 2'b0);
        end
        check_eq("accept_seen", 32'(got), 32'h1);
        check_eq("no_stray_rsp", early, 0);
        if (!got) return;
        check_eq("ready_onehot", 32'(o_ready), 32'(1 << r));
        check_eq("sel_n_active", 32'(o_sel_n), 32'(exp_sel));
        check_eq("busy_accept", 32'(o_busy), 32'h1);
        check_eq("mosi_msb", 32'(o_mosi), 32'(data[3'(w - 1)]));
        rr_ptr = (r + 1) % 2;
        set_req(r, data, slv, 1'b0);

        cyc = 0; pulses = 0; highs = 0; cap = 8'h0; done = 1'b0; prev = o_sclk;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq("ready_pulse", 32'(o_ready), 32'h0);
            if (o_sclk && !prev) begin
                pulses++;
                cap = {cap[6:0], o_mosi};
            end
            if (!o_sclk && prev) sreg = sreg << 1;
            if (o_sclk) highs++;
            prev = o_sclk;
            done = (o_rsp_valid != 2'b0);
        end
        check_eq("rsp_seen", 32'(done), 32'h1);
        check_eq("latency", cyc, d * (2 * w + 2) + 1);
        check_eq("rsp_valid_onehot", 32'(o_rsp_valid), 32'(1 << r));
        check_eq("rsp_data", 32'(o_rsp_data), 32'(exp_rsp));
        check_eq("sclk_pulses", pulses, w);
        check_eq("sclk_high_cycles", highs, w * d);
        check_eq("mosi_bits", 32'(cap & mask), 32'(data & mask));
        check_eq("sel_n_released", 32'(o_sel_n), 32'hF);
        check_eq("busy_done", 32'(o_busy), 32'h0);
        @(negedge clk);
        check_eq("rsp_valid_single", 32'(o_rsp_valid), 32'h0);
        check_eq("rsp_data_hold", 32'(o_rsp_data), 32'(exp_rsp));
    endtask

    // Both requesters held: expect alternating grants with one idle cycle between frames
    task automatic rr_test();
        int accepts, last, cyc, busy_low;
        logic prev_ready, seen;
        dsel = 1'b0;
        mode = 0;
        do_reset();
        req_valid_a = 2'b11; req_data_a = 8'h5C; req_slave_a = 4'b0100;
        accepts = 0; last = 0; cyc = 0; busy_low = 0; prev_ready = 1'b0;
        for (int i = 0; i < 400 && accepts < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (!busy_a) busy_low++;
            if (prev_ready) check_eq("rr_ready_pulse", 32'(req_ready_a), 32'h0);
            if (req_ready_a != 2'b0) begin
                check_eq("rr_grant", 32'(req_ready_a), 32'(1 << rr_ptr));
                if (accepts > 0) begin
                    check_eq("rr_gap", cyc - last, 42);
                    check_eq("rr_busy_low", busy_low, 1);
                end
                rr_ptr = (rr_ptr + 1) % 2;
                accepts++;
                last = cyc;
                busy_low = 0;
            end
            prev_ready = (req_ready_a != 2'b0);
        end
        check_eq("rr_accepts", accepts, 3);
        req_valid_a = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (rsp_valid_a != 2'b0);
        end
        check_eq("rr_drain", 32'(seen), 32'h1);
        @(negedge clk);
    endtask

    // Reset asserted in the third sclk high phase, then the held request restarts
    task automatic reset_mid_frame();
        int pulses;
        logic got, prev;
        dsel = 1'b0;
        mode = 0;
        do_reset();
        set_req(0, 8'h0B, 2'd2, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (req_ready_a != 2'b0);
        end
        check_eq("mid_accept", 32'(got), 32'h1);
        pulses = 0; prev = sclk_a;
        for (int i = 0; i < 200 && pulses < 3; i++) begin
            @(negedge clk);
            if (sclk_a && !prev) pulses++;
            prev = sclk_a;
        end
        check_eq("mid_third_pulse", pulses, 3);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sel_n", 32'(sel_n_a), 32'hF);
        check_eq("mid_rst_sclk", 32'(sclk_a), 32'h0);
        check_eq("mid_rst_busy", 32'(busy_a), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rr_ptr = 0;
        frame(0, 8'h0B, 2'd2, 0, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        dsel = 1'b0; mode = 0; sreg = 8'h0;
        req_valid_a = '0; req_data_a = '0; req_slave_a = '0;
        req_valid_b = '0; req_data_b = '0; req_slave_b = '0;
        @(negedge clk);
        do_reset();

        frame(0, 8'h0B, 2'd2, 0, 8'h00);
        frame(1, 8'($urandom), 2'd1, 1, 8'h00);
        frame(0, 8'($urandom), 2'd3, 2, 8'h00);
        repeat (10) frame(int'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 8'($urandom));

        rr_test();
        reset_mid_frame();

        dsel = 1'b1;
        frame(0, 8'hA5, 2'd1, 0, 8'h00);
        frame(1, 8'($urandom), 2'd3, 0, 8'h00);
        repeat (8) frame(int'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
